// File: rtl/alu_ex_stage.sv
// alu_ex_stage: registered execute stage.
// Takes {a, b, aluop, in_tag} on a request channel, computes the ALU result in
// the same cycle and stores it in a 2-entry in-order result queue. The queue
// head is presented on the response channel together with its tag.
// Optional build macro: ALU_EX_OVF_EN adds a per-entry signed overflow flag on
// port ovf (ADD/SUB only). Without it there is no ovf port or storage.
// dbg_state exposes the queue state (0 EMPTY, 1 ONE, 2 FULL) for checkers.
module alu_ex_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             iszero,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_cnt,
`ifdef ALU_EX_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid & in_ready,
    // a response transfers where out_valid & out_ready. in_ready and out_valid
    // come from registered state only, so neither channel combinationally
    // depends on the other. Data on both channels is held while valid & !ready.

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } qstate_t;

    qstate_t state, state_nx;

    logic                       rdy_en;
    logic                       head_ptr;
    logic                       tail_ptr;
    logic [1:0][WIDTH-1:0]      mem_s;
    logic [1:0]                 mem_z;
    logic [1:0]                 mem_ill;
    logic [1:0][TAG_W-1:0]      mem_tag;
    logic [CNT_W-1:0]           cnt;

    logic                       accept;
    logic                       deliver;
    logic [WIDTH-1:0]           alu_s;
    logic                       alu_ill;
    logic                       alu_z;
    logic [WIDTH-1:0]           sum;
    logic [WIDTH-1:0]           diff;

    assign in_ready  = rdy_en & (state != Q_FULL);
    assign out_valid = (state != Q_EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    assign s         = mem_s[head_ptr];
    assign iszero    = mem_z[head_ptr];
    assign illegal   = mem_ill[head_ptr];
    assign out_tag   = mem_tag[head_ptr];
    assign op_cnt    = cnt;
    assign dbg_state = state;

    assign sum  = a + b;
    assign diff = a - b;

    // ALU: decode aluop into the wrapped result; unsupported codes give 0 and flag illegal.
    always_comb begin
        alu_s   = '0;
        alu_ill = 1'b0;
        case (aluop)
            4'b0000: alu_s = a & b;
            4'b0001: alu_s = a | b;
            4'b0010: alu_s = sum;
            4'b0110: alu_s = diff;
            4'b0111: alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: alu_s = ~(a | b);
            default: alu_ill = 1'b1;
        endcase
        alu_z = (alu_s == '0);
    end

`ifdef ALU_EX_OVF_EN
    logic       alu_ovf;
    logic [1:0] mem_ovf;

    assign ovf = mem_ovf[head_ptr];

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips away from a.
    always_comb begin
        alu_ovf = 1'b0;
        if (aluop == 4'b0010)
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (aluop == 4'b0110)
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end

    // Overflow flag storage, written alongside the result entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_ovf <= '0;
        else if (accept)
            mem_ovf[tail_ptr] <= alu_ovf;
    end
`endif

    // Queue state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= Q_EMPTY;
        else
            state <= state_nx;
    end

    // Queue next state: push on accept, pop on deliver, both together keep the occupancy.
    always_comb begin
        state_nx = state;
        case (state)
            Q_EMPTY: if (accept) state_nx = Q_ONE;
            Q_ONE: begin
                if (accept && !deliver)
                    state_nx = Q_FULL;
                else if (deliver && !accept)
                    state_nx = Q_EMPTY;
            end
            Q_FULL:  if (deliver) state_nx = Q_ONE;
            default: state_nx = Q_EMPTY;
        endcase
    end

    // Hold in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    // Pointer update: 1-bit pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            if (accept)
                tail_ptr <= ~tail_ptr;
            if (deliver)
                head_ptr <= ~head_ptr;
        end
    end

    // Result storage: the tail entry takes the freshly computed result on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_s   <= '0;
            mem_z   <= '0;
            mem_ill <= '0;
            mem_tag <= '0;
        end else if (accept) begin
            mem_s[tail_ptr]   <= alu_s;
            mem_z[tail_ptr]   <= alu_z;
            mem_ill[tail_ptr] <= alu_ill;
            mem_tag[tail_ptr] <= in_tag;
        end
    end

    // Accepted-operation counter, wraps at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: reference model computes results with signed 64-bit
// arithmetic and tracks the result queue as a SystemVerilog queue.
module tb_alu_ex_stage;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int CW = 16;
    localparam int EW = W + TW + 3;   // {ovf, illegal, iszero, tag, s}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    aluop = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  s;
    logic          iszero;
    logic          illegal;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] op_cnt;
    logic [1:0]    dbg_state;
`ifdef ALU_EX_OVF_EN
    logic          ovf;
`endif

    alu_ex_stage #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluop     (aluop),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .iszero    (iszero),
        .illegal   (illegal),
        .out_tag   (out_tag),
        .op_cnt    (op_cnt),
`ifdef ALU_EX_OVF_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] model_cnt = '0;
    bit            rdy_en = 1'b0;
    int            vectors = 0;
    int            errors = 0;

    function automatic logic [EW-1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic [3:0] op, input logic [TW-1:0] t);
        longint       sx, sy, r, maxv, minv;
        logic [W-1:0] res;
        logic         ill, ov;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxv = (longint'(1) << (W-1)) - 1;
        minv = -(longint'(1) << (W-1));
        res  = '0;
        ill  = 1'b0;
        ov   = 1'b0;
        case (op)
            4'd0:  res = x & y;
            4'd1:  res = x | y;
            4'd2:  begin r = sx + sy; res = r[W-1:0]; ov = (r > maxv) || (r < minv); end
            4'd6:  begin r = sx - sy; res = r[W-1:0]; ov = (r > maxv) || (r < minv); end
            4'd7:  res = (sx < sy) ? 1 : 0;
            4'd12: res = ~(x | y);
            default: ill = 1'b1;
        endcase
        return {ov, ill, (res == '0), t, res};
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: check outputs against the model, then apply the edge to the model.
    task automatic step();
        logic [EW-1:0] h;
        bit er, acc, del;
        #1;
        er = rdy_en && (exp_q.size() < 2);
        vectors++;
        if (in_ready !== er) begin
            errors++; $display("FAIL in_ready: got %b expected %b at %0t", in_ready, er, $time);
        end
        vectors++;
        if (out_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_q.size() != 0, $time);
        end
        vectors++;
        if (op_cnt !== model_cnt) begin
            errors++; $display("FAIL op_cnt: got %0d expected %0d at %0t", op_cnt, model_cnt, $time);
        end
        vectors++;
        if (dbg_state !== 2'(exp_q.size())) begin
            errors++; $display("FAIL dbg_state: got %0d expected %0d at %0t", dbg_state, exp_q.size(), $time);
        end
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            vectors++;
            if (s !== h[W-1:0]) begin
                errors++; $display("FAIL s: got %h expected %h at %0t", s, h[W-1:0], $time);
            end
            vectors++;
            if (out_tag !== h[W+TW-1:W]) begin
                errors++; $display("FAIL out_tag: got %0d expected %0d at %0t", out_tag, h[W+TW-1:W], $time);
            end
            vectors++;
            if (iszero !== h[W+TW]) begin
                errors++; $display("FAIL iszero: got %b expected %b at %0t", iszero, h[W+TW], $time);
            end
            vectors++;
            if (illegal !== h[W+TW+1]) begin
                errors++; $display("FAIL illegal: got %b expected %b at %0t", illegal, h[W+TW+1], $time);
            end
`ifdef ALU_EX_OVF_EN
            vectors++;
            if (ovf !== h[W+TW+2]) begin
                errors++; $display("FAIL ovf: got %b expected %b at %0t", ovf, h[W+TW+2], $time);
            end
`endif
        end
        acc = in_valid && er;
        del = (exp_q.size() != 0) && out_ready;
        @(posedge clk);
        if (del) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(ref_result(a, b, aluop, in_tag));
            model_cnt++;
        end
        rdy_en = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] op, input logic [TW-1:0] t, input bit r);
        in_valid  = v;
        a         = x;
        b         = y;
        aluop     = op;
        in_tag    = t;
        out_ready = r;
        step();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        model_cnt = '0;
        rdy_en    = 1'b0;
        rst_n     = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, iszero, illegal} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, iszero, illegal});
        end
        vectors++;
        if ({s, out_tag, op_cnt} !== '0) begin
            errors++; $display("FAIL reset_data: got s=%h tag=%0d cnt=%0d expected all 0", s, out_tag, op_cnt);
        end
        @(negedge clk);
        exp_q.delete();
        model_cnt = '0;
        rdy_en    = 1'b0;
        rst_n     = 1'b1;
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);   // in_ready still 0 before first edge
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);   // in_ready now 1
    endtask

    task automatic test_opcodes();
        logic [3:0]   ops[6]  = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [W-1:0] exp_s[6] = '{32'd0, 32'd3, 32'd3, 32'd1, 32'd0, 32'hFFFF_FFFC};
        bit           exp_z[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'd2, 32'd1, ops[k], TW'(k), 1'b1);
            vectors++;
            if (s !== exp_s[k] || iszero !== exp_z[k] || out_valid !== 1'b1) begin
                errors++; $display("FAIL op_table[%0d]: got s=%h z=%b v=%b expected s=%h z=%b v=1",
                                   k, s, iszero, out_valid, exp_s[k], exp_z[k]);
            end
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    task automatic test_slt();
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 4'd5, 1'b1);
        vectors++;
        if (s !== 32'd1 || iszero !== 1'b0) begin
            errors++; $display("FAIL slt_neg: got s=%h z=%b expected s=1 z=0", s, iszero);
        end
        drive(1'b1, 32'd1, 32'hFFFF_FFFF, 4'd7, 4'd6, 1'b1);
        vectors++;
        if (s !== 32'd0 || iszero !== 1'b1) begin
            errors++; $display("FAIL slt_pos: got s=%h z=%b expected s=0 z=1", s, iszero);
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b0, '0, '0, 4'd0, '0, 1'b0);
        drive(1'b1, 32'd10, 32'd1, 4'd2, 4'd1, 1'b0);
        drive(1'b1, 32'd20, 32'd2, 4'd2, 4'd2, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 32'd30, 32'd3, 4'd2, 4'd3, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 32'd30, 32'd3, 4'd2, 4'd3, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
        vectors++;
        if (op_cnt !== 16'd3 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_final: got cnt=%0d v=%b expected cnt=3 v=0", op_cnt, out_valid);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, rand_word(), rand_word(), 4'd2, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_word(), rand_word(), 4'd6, TW'(i + 1), 1'b1);
            vectors++;
            if (dbg_state !== 2'd1 || exp_q.size() != 1) begin
                errors++; $display("FAIL stream_count: got %0d expected 1", dbg_state);
            end
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'd5, 32'd5, 4'b0011, 4'd9, 1'b1);
        vectors++;
        if (s !== 32'd0 || iszero !== 1'b1 || illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_op: got s=%h z=%b ill=%b expected s=0 z=1 ill=1", s, iszero, illegal);
        end
        drive(1'b1, 32'd5, 32'd5, 4'd1, 4'd10, 1'b1);
        vectors++;
        if (illegal !== 1'b0 || s !== 32'd5) begin
            errors++; $display("FAIL illegal_clear: got ill=%b s=%h expected ill=0 s=5", illegal, s);
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] legal[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [3:0] op;
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 5)];
            drive(1'($urandom_range(0, 3) != 0), rand_word(), rand_word(), op,
                  TW'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

`ifdef ALU_EX_OVF_EN
    task automatic test_ovf();
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd2, 4'd1, 1'b1);
        vectors++;
        if (s !== 32'h8000_0000 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_add: got s=%h ovf=%b expected s=80000000 ovf=1", s, ovf);
        end
        drive(1'b1, 32'h8000_0000, 32'd1, 4'd6, 4'd2, 1'b1);
        vectors++;
        if (s !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sub: got s=%h ovf=%b expected s=7fffffff ovf=1", s, ovf);
        end
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd0, 4'd3, 1'b1);
        vectors++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_and: got %b expected 0", ovf);
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask
`endif

    task automatic test_cnt_wrap();
        do_reset();
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
        for (int i = 0; i < 65535; i++) drive(1'b1, 32'(i), 32'd3, 4'd2, TW'(i), 1'b1);
        vectors++;
        if (op_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_max: got %h expected ffff", op_cnt);
        end
        drive(1'b1, 32'd1, 32'd1, 4'd2, 4'd0, 1'b1);
        vectors++;
        if (op_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_wrap: got %h expected 0000", op_cnt);
        end
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'd7, 32'd8, 4'd2, 4'd1, 1'b0);
        drive(1'b1, 32'd9, 32'd8, 4'd6, 4'd2, 1'b0);
        drive(1'b0, '0, '0, 4'd0, '0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || op_cnt !== '0 || in_ready !== 1'b0 || s !== '0) begin
            errors++; $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b s=%h expected 0 0 0 0",
                               out_valid, op_cnt, in_ready, s);
        end
        exp_q.delete();
        model_cnt = '0;
        rdy_en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
        drive(1'b1, 32'd4, 32'd4, 4'd6, 4'd11, 1'b1);
        drive(1'b0, '0, '0, 4'd0, '0, 1'b1);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_opcodes();
        test_slt();
        test_backpressure();
        test_stream();
        test_illegal();
        test_random();
`ifdef ALU_EX_OVF_EN
        test_ovf();
`endif
        test_cnt_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Registered execute-stage responder for the pipelined datapath; it is the consuming end of the operand/opcode interface that decode (or a bench) drives.
- Accepts {a, b, aluop, tag} on a valid/ready request channel and computes the 32-bit ALU result.
- Returns {s, iszero, tag} through a 2-entry in-order result queue on a valid/ready response channel.
- Decouples the ALU from writeback stalls and keeps per-result tags for hazard/forwarding bookkeeping.

Parameters:
- WIDTH, 32, datapath width of a, b and s.
- TAG_W, 4, width of the opaque tag carried from request to response.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- aluop  in  4  operation code.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  response valid.
- out_ready  in  1  response ready.
- s  out  WIDTH  result.
- iszero  out  1  s == 0.
- illegal  out  1  head result came from an unsupported aluop.
- out_tag  out  TAG_W  tag of head result.
- op_cnt  out  CNT_W  number of accepted requests, wraps.

Behaviour:
- Reset is asynchronous, active-low, one clock. While rst_n=0:
  - queue count=0, head/tail pointers=0.
  - out_valid=0, s=0, iszero=0, illegal=0, out_tag=0, op_cnt=0.
  - in_ready=0 during reset; in_ready=1 from the first edge after release.
- Opcodes (MIPS-style):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT: signed; s=1 if $signed(a)<$signed(b), else 0.
  - 1100 NOR.
  - Any other code: s=0, illegal=1.
- Arithmetic is modulo 2^WIDTH; carries are discarded. iszero is computed from the final s.
- Handshake:
  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
  - in_ready = (count != 2). It depends only on registered state, not on out_ready.
  - out_valid = (count != 0). s, iszero, illegal and out_tag present the head entry.
- Latency: a request accepted at edge N is computed combinationally and written to the tail at edge N. Its result is visible on the outputs after edge N (1 cycle) if the queue was empty.
- Queue states are EMPTY (count 0), ONE (count 1) and FULL (count 2). Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; deliver only -> EMPTY; accept and deliver together -> ONE (push and pop in the same edge).
  - FULL: deliver -> ONE. No accept is possible while FULL because in_ready=0.
- Ordering is strict FIFO; tags return in acceptance order.
- Pointers are 1 bit and wrap 1->0.
- Output data is stable while out_valid=1 and out_ready=0.
- op_cnt increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- in_valid with in_ready=0 has no effect. The upstream stage holds its request.
- Reset asserted mid-operation flushes queued results immediately (asynchronous). Pending requests are dropped and not replayed.

Optional Feature:
- Macro ALU_EX_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), stored per queue entry and reset to 0.
  - ADD: ovf=1 when a and b have the same sign and the sign of s differs.
  - SUB: ovf=1 when a and b have different signs and the sign of s differs from a.
  - All other opcodes: ovf=0.
  - s is still the wrapped result.
- Not defined: no ovf port and no extra storage; behaviour is otherwise identical.

Test Plan:
- a=2, b=1, out_ready=1, one request per cycle with aluop 0000, 0001, 0010, 0110, 0111, 1100 -> s=0, 3, 3, 1, 0, 0xFFFFFFFC. iszero=1 for AND and SLT only. Each result appears 1 cycle after its accept.
- a=0xFFFFFFFF (-1), b=1, aluop=0111 -> s=1, iszero=0. Swap operands -> s=0, iszero=1.
- out_ready=0, three back-to-back requests with tags 1, 2, 3 -> in_ready drops after tags 1 and 2 are accepted, and tag 3 is held. Raise out_ready -> tags return 1, 2, 3 in order, and op_cnt ends at 3.
- Queue at count=1 with in_valid=1 and out_ready=1 held for 10 cycles -> count stays 1, throughput is 1 result per cycle, and no request is lost.
- aluop=0011, a=5, b=5 -> s=0, iszero=1, illegal=1. The next legal op returns illegal=0.
- Two results queued, drop rst_n mid-cycle -> out_valid=0 and op_cnt=0 without waiting for a clock edge. With ALU_EX_OVF_EN defined: a=0x7FFFFFFF, b=1, ADD -> s=0x80000000, ovf=1.
